bubble_hit_detector: RTL and testbench

Frame-level collision arbiter between the bouncing-bubble mover and the rope and player objects. It watches per-pixel drawing requests during the raster scan and latches any overlaps. Once per frame it reports the result as single-cycle pulses. The `collision` pulse drives the bubble mover's position reset, while score, lives and game-over status feed the HUD and the game controller.

---
 rtl/bubble_hit_detector_if.sv | 25 ++
 rtl/bubble_hit_detector.sv | 126 ++++++++++++
 tb/tb_bubble_hit_detector.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/bubble_hit_detector_if.sv
// rtl/bubble_hit_detector_if.sv - pixel overlap inputs and frame report outputs of the bubble hit detector
interface bubble_hit_detector_if;
  logic        startOfFrame;
  logic        ballDrawingRequest;
  logic        ropeDrawingRequest;
  logic        playerDrawingRequest;
  logic        collision;
  logic        ropeHit;
  logic        playerHit;
  logic [15:0] score;
  logic [2:0]  lives;
  logic        gameOver;

  // Raster/game side: drives pixel requests, consumes frame reports
  modport master (
    output startOfFrame, ballDrawingRequest, ropeDrawingRequest, playerDrawingRequest,
    input  collision, ropeHit, playerHit, score, lives, gameOver
  );

  // Detector side
  modport slave (
    input  startOfFrame, ballDrawingRequest, ropeDrawingRequest, playerDrawingRequest,
    output collision, ropeHit, playerHit, score, lives, gameOver
  );
endinterface

// File: rtl/bubble_hit_detector.sv
// rtl/bubble_hit_detector.sv - frame-level bubble/rope/player collision arbiter with score, lives and cooldown
module bubble_hit_detector #(
  parameter int INITIAL_LIVES   = 3,
  parameter int COOLDOWN_FRAMES = 60,
  parameter int HIT_POINTS      = 10
) (
  input logic                   clk,
  input logic                   resetN,
  bubble_hit_detector_if.slave  bus
);

  typedef enum logic [1:0] {RUN, COOLDOWN, GAME_OVER} state_t;

  localparam logic [7:0]  CD_INIT    = 8'(COOLDOWN_FRAMES);
  localparam logic [2:0]  LIVES_INIT = 3'(INITIAL_LIVES);
  localparam logic [16:0] POINTS     = 17'(HIT_POINTS);

  state_t      state_q, state_d;
  logic        rope_flag_q, rope_flag_d;
  logic        player_flag_q, player_flag_d;
  logic [7:0]  cd_cnt_q, cd_cnt_d;
  logic [15:0] score_q, score_d;
  logic [2:0]  lives_q, lives_d;
  logic        game_over_q, game_over_d;
  logic        rope_hit_q, rope_hit_d;
  logic        player_hit_q, player_hit_d;
  logic        collision_q, collision_d;

  logic [16:0] score_sum;
  logic [15:0] score_sat;
  logic [2:0]  lives_dec;

  assign score_sum = {1'b0, score_q} + POINTS;
  assign score_sat = score_sum[16] ? 16'hFFFF : score_sum[15:0];
  assign lives_dec = (lives_q == 3'd0) ? 3'd0 : lives_q - 3'd1;

  // Overlap latches: cleared at frame start, but a same-cycle overlap re-sets them for the new frame
  always_comb begin
    rope_flag_d   = (bus.startOfFrame ? 1'b0 : rope_flag_q)
                  | (bus.ballDrawingRequest & bus.ropeDrawingRequest);
    player_flag_d = (bus.startOfFrame ? 1'b0 : player_flag_q)
                  | (bus.ballDrawingRequest & bus.playerDrawingRequest);
  end

  // Once-per-frame evaluation of last frame's flags; player hit outranks rope hit
  always_comb begin
    state_d      = state_q;
    cd_cnt_d     = cd_cnt_q;
    score_d      = score_q;
    lives_d      = lives_q;
    game_over_d  = game_over_q;
    rope_hit_d   = 1'b0;
    player_hit_d = 1'b0;
    if (bus.startOfFrame) begin
      case (state_q)
        RUN: begin
          if (player_flag_q) begin
            player_hit_d = 1'b1;
            lives_d      = lives_dec;
            if (lives_dec == 3'd0) begin
              state_d     = GAME_OVER;
              game_over_d = 1'b1;
            end else begin
              cd_cnt_d = CD_INIT;
              state_d  = COOLDOWN;
            end
          end else if (rope_flag_q) begin
            rope_hit_d = 1'b1;
            score_d    = score_sat;
          end
        end
        COOLDOWN: begin
          // Player is invulnerable here, including the frame where the count expires
          if (rope_flag_q) begin
            rope_hit_d = 1'b1;
            score_d    = score_sat;
          end
          if (cd_cnt_q <= 8'd1) begin
            cd_cnt_d = 8'd0;
            state_d  = RUN;
          end else begin
            cd_cnt_d = cd_cnt_q - 8'd1;
          end
        end
        GAME_OVER: ;
        default: state_d = RUN;
      endcase
    end
    collision_d = rope_hit_d | player_hit_d;
  end

  // State, counters and registered report pulses
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q       <= RUN;
      rope_flag_q   <= 1'b0;
      player_flag_q <= 1'b0;
      cd_cnt_q      <= 8'd0;
      score_q       <= 16'd0;
      lives_q       <= LIVES_INIT;
      game_over_q   <= 1'b0;
      rope_hit_q    <= 1'b0;
      player_hit_q  <= 1'b0;
      collision_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      rope_flag_q   <= rope_flag_d;
      player_flag_q <= player_flag_d;
      cd_cnt_q      <= cd_cnt_d;
      score_q       <= score_d;
      lives_q       <= lives_d;
      game_over_q   <= game_over_d;
      rope_hit_q    <= rope_hit_d;
      player_hit_q  <= player_hit_d;
      collision_q   <= collision_d;
    end
  end

  assign bus.collision = collision_q;
  assign bus.ropeHit   = rope_hit_q;
  assign bus.playerHit = player_hit_q;
  assign bus.score     = score_q;
  assign bus.lives     = lives_q;
  assign bus.gameOver  = game_over_q;

endmodule

// File: tb/tb_bubble_hit_detector.sv
// tb/tb_bubble_hit_detector.sv - directed self-checking bench for bubble_hit_detector
module tb_bubble_hit_detector;

  logic clk = 1'b0;
  logic resetN = 1'b0;
  int   tests = 0;
  int   fails = 0;

  logic        c_col, c_rope, c_player, c_go, c_after;
  logic [15:0] c_score;
  logic [2:0]  c_lives;

  bubble_hit_detector_if bus ();

  bubble_hit_detector #(
    .INITIAL_LIVES  (3),
    .COOLDOWN_FRAMES(4),
    .HIT_POINTS     (10)
  ) dut (
    .clk   (clk),
    .resetN(resetN),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Drive the pixel inputs for n cycles (changes land on falling edges)
  task automatic drive(input logic s, b, r, p, input int n);
    repeat (n) begin
      @(negedge clk);
      bus.startOfFrame = s;
      bus.ballDrawingRequest = b;
      bus.ropeDrawingRequest = r;
      bus.playerDrawingRequest = p;
    end
  endtask

  // One startOfFrame cycle (with optional overlap on it), capture the report, then one idle cycle
  task automatic eval_sof(input logic b, r, p);
    drive(1'b1, b, r, p, 1);
    @(posedge clk); #1;
    c_col = bus.collision; c_rope = bus.ropeHit; c_player = bus.playerHit;
    c_score = bus.score; c_lives = bus.lives; c_go = bus.gameOver;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1);
    @(posedge clk); #1;
    c_after = bus.collision | bus.ropeHit | bus.playerHit;
  endtask

  task automatic do_reset();
    @(negedge clk);
    resetN = 1'b0;
    bus.startOfFrame = 1'b0; bus.ballDrawingRequest = 1'b0;
    bus.ropeDrawingRequest = 1'b0; bus.playerDrawingRequest = 1'b0;
    @(negedge clk);
    resetN = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    tests++; if (bus.collision !== 1'b0) begin fails++; $display("FAIL reset_collision got=%0b exp=0", bus.collision); end
    tests++; if (bus.ropeHit !== 1'b0) begin fails++; $display("FAIL reset_ropeHit got=%0b exp=0", bus.ropeHit); end
    tests++; if (bus.playerHit !== 1'b0) begin fails++; $display("FAIL reset_playerHit got=%0b exp=0", bus.playerHit); end
    tests++; if (bus.gameOver !== 1'b0) begin fails++; $display("FAIL reset_gameOver got=%0b exp=0", bus.gameOver); end
    tests++; if (bus.score !== 16'd0) begin fails++; $display("FAIL reset_score got=%0d exp=0", bus.score); end
    tests++; if (bus.lives !== 3'd3) begin fails++; $display("FAIL reset_lives got=%0d exp=3", bus.lives); end
  endtask

  task automatic test_rope_hit();
    do_reset();
    drive(1'b0, 1'b1, 1'b1, 1'b0, 3);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 2);
    eval_sof(1'b0, 1'b0, 1'b0);
    tests++; if (c_rope !== 1'b1) begin fails++; $display("FAIL rope_pulse got=%0b exp=1", c_rope); end
    tests++; if (c_col !== 1'b1) begin fails++; $display("FAIL rope_collision got=%0b exp=1", c_col); end
    tests++; if (c_player !== 1'b0) begin fails++; $display("FAIL rope_no_player got=%0b exp=0", c_player); end
    tests++; if (c_score !== 16'd10) begin fails++; $display("FAIL rope_score got=%0d exp=10", c_score); end
    tests++; if (c_lives !== 3'd3) begin fails++; $display("FAIL rope_lives got=%0d exp=3", c_lives); end
    tests++; if (c_after !== 1'b0) begin fails++; $display("FAIL rope_pulse_width got=%0b exp=0", c_after); end
    eval_sof(1'b0, 1'b0, 1'b0);
    tests++; if (c_col !== 1'b0) begin fails++; $display("FAIL rope_single_report got=%0b exp=0", c_col); end
    tests++; if (c_score !== 16'd10) begin fails++; $display("FAIL rope_score_hold got=%0d exp=10", c_score); end
  endtask

  task automatic test_cooldown();
    do_reset();
    drive(1'b0, 1'b1, 1'b0, 1'b1, 2);
    eval_sof(1'b0, 1'b0, 1'b0);
    tests++; if (c_player !== 1'b1) begin fails++; $display("FAIL cd_first_hit got=%0b exp=1", c_player); end
    tests++; if (c_lives !== 3'd2) begin fails++; $display("FAIL cd_first_lives got=%0d exp=2", c_lives); end
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b1, 1'b0, 1'b1, 2);
      eval_sof(1'b0, 1'b0, 1'b0);
      tests++; if (c_col !== 1'b0) begin fails++; $display("FAIL cd_ignored_%0d got=%0b exp=0", i, c_col); end
      tests++; if (c_lives !== 3'd2) begin fails++; $display("FAIL cd_lives_%0d got=%0d exp=2", i, c_lives); end
    end
    drive(1'b0, 1'b1, 1'b0, 1'b1, 2);
    eval_sof(1'b0, 1'b0, 1'b0);
    tests++; if (c_player !== 1'b1) begin fails++; $display("FAIL cd_second_hit got=%0b exp=1", c_player); end
    tests++; if (c_col !== 1'b1) begin fails++; $display("FAIL cd_second_collision got=%0b exp=1", c_col); end
    tests++; if (c_lives !== 3'd1) begin fails++; $display("FAIL cd_second_lives got=%0d exp=1", c_lives); end
    tests++; if (c_go !== 1'b0) begin fails++; $display("FAIL cd_no_gameover got=%0b exp=0", c_go); end
  endtask

  task automatic test_priority();
    do_reset();
    drive(1'b0, 1'b1, 1'b1, 1'b1, 2);
    eval_sof(1'b0, 1'b0, 1'b0);
    tests++; if (c_player !== 1'b1) begin fails++; $display("FAIL prio_player got=%0b exp=1", c_player); end
    tests++; if (c_rope !== 1'b0) begin fails++; $display("FAIL prio_rope_dropped got=%0b exp=0", c_rope); end
    tests++; if (c_score !== 16'd0) begin fails++; $display("FAIL prio_score got=%0d exp=0", c_score); end
    tests++; if (c_lives !== 3'd2) begin fails++; $display("FAIL prio_lives got=%0d exp=2", c_lives); end
    drive(1'b0, 1'b1, 1'b1, 1'b1, 2);
    eval_sof(1'b0, 1'b0, 1'b0);
    tests++; if (c_rope !== 1'b1) begin fails++; $display("FAIL prio_cd_rope got=%0b exp=1", c_rope); end
    tests++; if (c_player !== 1'b0) begin fails++; $display("FAIL prio_cd_player got=%0b exp=0", c_player); end
    tests++; if (c_col !== 1'b1) begin fails++; $display("FAIL prio_cd_collision got=%0b exp=1", c_col); end
    tests++; if (c_score !== 16'd10) begin fails++; $display("FAIL prio_cd_score got=%0d exp=10", c_score); end
  endtask

  task automatic test_game_over();
    do_reset();
    drive(1'b0, 1'b1, 1'b1, 1'b0, 1);
    eval_sof(1'b0, 1'b0, 1'b0);
    for (int h = 0; h < 3; h++) begin
      drive(1'b0, 1'b1, 1'b0, 1'b1, 1);
      eval_sof(1'b0, 1'b0, 1'b0);
      if (h < 2) begin
        for (int k = 0; k < 4; k++) eval_sof(1'b0, 1'b0, 1'b0);
      end
    end
    tests++; if (c_player !== 1'b1) begin fails++; $display("FAIL go_third_hit got=%0b exp=1", c_player); end
    tests++; if (c_lives !== 3'd0) begin fails++; $display("FAIL go_lives got=%0d exp=0", c_lives); end
    tests++; if (c_go !== 1'b1) begin fails++; $display("FAIL go_flag got=%0b exp=1", c_go); end
    drive(1'b0, 1'b1, 1'b1, 1'b1, 2);
    eval_sof(1'b0, 1'b0, 1'b0);
    tests++; if (c_col !== 1'b0) begin fails++; $display("FAIL go_no_pulse got=%0b exp=0", c_col); end
    tests++; if (c_score !== 16'd10) begin fails++; $display("FAIL go_score_frozen got=%0d exp=10", c_score); end
    tests++; if (c_lives !== 3'd0) begin fails++; $display("FAIL go_lives_frozen got=%0d exp=0", c_lives); end
    tests++; if (c_go !== 1'b1) begin fails++; $display("FAIL go_sticky got=%0b exp=1", c_go); end
  endtask

  task automatic test_sof_overlap();
    do_reset();
    eval_sof(1'b1, 1'b1, 1'b0);
    tests++; if (c_rope !== 1'b0) begin fails++; $display("FAIL sofov_not_now got=%0b exp=0", c_rope); end
    tests++; if (c_score !== 16'd0) begin fails++; $display("FAIL sofov_score_now got=%0d exp=0", c_score); end
    eval_sof(1'b0, 1'b0, 1'b0);
    tests++; if (c_rope !== 1'b1) begin fails++; $display("FAIL sofov_next got=%0b exp=1", c_rope); end
    tests++; if (c_score !== 16'd10) begin fails++; $display("FAIL sofov_score_next got=%0d exp=10", c_score); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    drive(1'b0, 1'b1, 1'b1, 1'b0, 1);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1);
    @(posedge clk); #1;
    tests++; if (bus.ropeHit !== 1'b1) begin fails++; $display("FAIL b2b_first got=%0b exp=1", bus.ropeHit); end
    @(posedge clk); #1;
    tests++; if (bus.collision !== 1'b0) begin fails++; $display("FAIL b2b_second got=%0b exp=0", bus.collision); end
    tests++; if (bus.score !== 16'd10) begin fails++; $display("FAIL b2b_score got=%0d exp=10", bus.score); end
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1);
  endtask

  task automatic test_reset_mid_cooldown();
    do_reset();
    drive(1'b0, 1'b1, 1'b0, 1'b1, 1);
    eval_sof(1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 1'b1, 1'b0, 1);
    @(negedge clk);
    resetN = 1'b0;
    bus.ballDrawingRequest = 1'b0; bus.ropeDrawingRequest = 1'b0;
    #1;
    tests++; if (bus.lives !== 3'd3) begin fails++; $display("FAIL rst_async_lives got=%0d exp=3", bus.lives); end
    tests++; if (bus.collision !== 1'b0) begin fails++; $display("FAIL rst_async_collision got=%0b exp=0", bus.collision); end
    @(negedge clk);
    resetN = 1'b1;
    eval_sof(1'b0, 1'b0, 1'b0);
    tests++; if (c_col !== 1'b0) begin fails++; $display("FAIL rst_flag_lost got=%0b exp=0", c_col); end
    drive(1'b0, 1'b1, 1'b0, 1'b1, 1);
    eval_sof(1'b0, 1'b0, 1'b0);
    tests++; if (c_player !== 1'b1) begin fails++; $display("FAIL rst_run_state got=%0b exp=1", c_player); end
    tests++; if (c_lives !== 3'd2) begin fails++; $display("FAIL rst_run_lives got=%0d exp=2", c_lives); end
  endtask

  task automatic test_saturation();
    do_reset();
    for (int i = 0; i < 6553; i++) begin
      drive(1'b0, 1'b1, 1'b1, 1'b0, 1);
      eval_sof(1'b0, 1'b0, 1'b0);
    end
    tests++; if (c_score !== 16'd65530) begin fails++; $display("FAIL sat_preload got=%0d exp=65530", c_score); end
    drive(1'b0, 1'b1, 1'b1, 1'b0, 1);
    eval_sof(1'b0, 1'b0, 1'b0);
    tests++; if (c_score !== 16'd65535) begin fails++; $display("FAIL sat_clip got=%0d exp=65535", c_score); end
    drive(1'b0, 1'b1, 1'b1, 1'b0, 1);
    eval_sof(1'b0, 1'b0, 1'b0);
    tests++; if (c_score !== 16'd65535) begin fails++; $display("FAIL sat_hold got=%0d exp=65535", c_score); end
    tests++; if (c_rope !== 1'b1) begin fails++; $display("FAIL sat_pulse got=%0b exp=1", c_rope); end
  endtask

  initial begin
    bus.startOfFrame = 1'b0; bus.ballDrawingRequest = 1'b0;
    bus.ropeDrawingRequest = 1'b0; bus.playerDrawingRequest = 1'b0;
    test_reset();
    test_rope_hit();
    test_cooldown();
    test_priority();
    test_game_over();
    test_sof_overlap();
    test_back_to_back();
    test_reset_mid_cooldown();
    test_saturation();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
